caliptra_prim_fifo_sync_mc: RTL and testbench

//  Single-clock, multi-channel FIFO: NumCh independent queues share one write port (channel-tagged) and one read port.

---
 rtl/caliptra_prim_fifo_sync_mc.sv | 231 +++++++++++++++++++++++
 tb/tb_caliptra_prim_fifo_sync_mc.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/caliptra_prim_fifo_sync_mc.sv
// Single-clock multi-channel FIFO: per-channel queues sharing one tagged write port and one
// round-robin arbitrated read port whose grant is held until the beat is accepted.

module caliptra_prim_fifo_sync_mc #(
    parameter int unsigned Width               = 16,
    parameter int unsigned Depth               = 4,
    parameter int unsigned NumCh               = 2,
    parameter int unsigned AlmostFullTh        = 3,
    parameter bit          OutputZeroIfInvalid = 1'b1,
    localparam int unsigned DepthW             = $clog2(Depth + 1),
    localparam int unsigned ChW                = $clog2(NumCh),
    localparam int unsigned PtrW               = $clog2(Depth) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     wvalid_i,
    input  logic [ChW-1:0]           wch_i,
    input  logic [Width-1:0]         wdata_i,
    output logic                     wready_o,
    output logic                     rvalid_o,
    input  logic                     rready_i,
    output logic [Width-1:0]         rdata_o,
    output logic [ChW-1:0]           rch_o,
    output logic [NumCh*DepthW-1:0]  depth_o,
    output logic [NumCh-1:0]         afull_o,
    output logic [NumCh-1:0]         full_o
);

    localparam int unsigned IdxW = PtrW - 1;

    logic [PtrW-1:0]  wptr_r    [NumCh];
    logic [PtrW-1:0]  rptr_r    [NumCh];
    logic [Width-1:0] storage_r [NumCh][Depth];

    logic [NumCh-1:0]  empty_s;
    logic [NumCh-1:0]  full_s;
    logic [DepthW-1:0] depth_s [NumCh];

    logic             wch_ok_s;
    logic             wfull_s;
    logic             wready_s;
    logic             push_s;
    logic             any_s;
    logic             rvalid_s;
    logic             pop_s;
    logic [ChW-1:0]   arb_grant_s;
    logic [ChW-1:0]   grant_s;
    logic [Width-1:0] head_s;

    logic [ChW-1:0]   prio_r;
    logic             lock_r;
    logic [ChW-1:0]   lock_ch_r;

    // Channel after ch, wrapping at NumCh (NumCh need not be a power of two).
    function automatic logic [ChW-1:0] next_ch(input logic [ChW-1:0] ch);
        logic [ChW-1:0] nxt;
        if (int'(ch) + 1 >= int'(NumCh)) begin
            nxt = {ChW{1'b0}};
        end else begin
            nxt = ch + ChW'(1);
        end
        return nxt;
    endfunction

    for (genvar c = 0; c < NumCh; c++) begin : gen_ch_status
        logic [PtrW-1:0] occ_s;
        assign occ_s       = wptr_r[c] - rptr_r[c];
        assign depth_s[c]  = DepthW'(occ_s);
        assign empty_s[c]  = (wptr_r[c] == rptr_r[c]);
        assign full_s[c]   = (wptr_r[c][PtrW-1] != rptr_r[c][PtrW-1]) &&
                             (wptr_r[c][IdxW-1:0] == rptr_r[c][IdxW-1:0]);
        assign depth_o[c*DepthW +: DepthW] = depth_s[c];
        assign afull_o[c]  = (depth_s[c] >= DepthW'(AlmostFullTh));
        assign full_o[c]   = full_s[c];
    end

    // Write-side acceptance; an out-of-range channel tag is treated as full.
    always_comb begin
        wch_ok_s = 1'b0;
        wfull_s  = 1'b1;
        if (int'(wch_i) < int'(NumCh)) begin
            wch_ok_s = 1'b1;
            wfull_s  = full_s[wch_i];
        end else begin
            wch_ok_s = 1'b0;
            wfull_s  = 1'b1;
        end
    end

    assign wready_s = wch_ok_s & ~wfull_s & ~clr_i;
    assign push_s   = wvalid_i & wready_s;

    // Cyclic search for the first non-empty channel starting at prio_r.
    always_comb begin
        logic        found;
        int unsigned idx;
        found       = 1'b0;
        idx         = 0;
        arb_grant_s = {ChW{1'b0}};
        for (int i = 0; i < int'(NumCh); i++) begin
            idx = (int'(prio_r) + i) % NumCh;
            if (!found && !empty_s[ChW'(idx)]) begin
                found       = 1'b1;
                arb_grant_s = ChW'(idx);
            end else begin
                found = found;
            end
        end
    end

    assign any_s    = |(~empty_s);
    assign rvalid_s = any_s & ~clr_i;
    assign grant_s  = lock_r ? lock_ch_r : arb_grant_s;
    assign pop_s    = rvalid_s & rready_i;

    // Head of the granted channel, masked while nothing is offered.
    always_comb begin
        head_s = storage_r[grant_s][rptr_r[grant_s][IdxW-1:0]];
        if (OutputZeroIfInvalid && !rvalid_s) begin
            rdata_o = {Width{1'b0}};
            rch_o   = {ChW{1'b0}};
        end else begin
            rdata_o = head_s;
            rch_o   = grant_s;
        end
    end

    assign wready_o = wready_s;
    assign rvalid_o = rvalid_s;

    // Per-channel pointer update; clear wins over any handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < int'(NumCh); c++) begin
                wptr_r[c] <= {PtrW{1'b0}};
                rptr_r[c] <= {PtrW{1'b0}};
            end
        end else if (clr_i) begin
            for (int c = 0; c < int'(NumCh); c++) begin
                wptr_r[c] <= {PtrW{1'b0}};
                rptr_r[c] <= {PtrW{1'b0}};
            end
        end else begin
            for (int c = 0; c < int'(NumCh); c++) begin
                if (push_s && (wch_i == ChW'(c))) begin
                    wptr_r[c] <= wptr_r[c] + PtrW'(1);
                end
                if (pop_s && (grant_s == ChW'(c))) begin
                    rptr_r[c] <= rptr_r[c] + PtrW'(1);
                end
            end
        end
    end

    // Arbiter state: rotate priority after a pop, hold the grant while the consumer stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_r    <= {ChW{1'b0}};
            lock_r    <= 1'b0;
            lock_ch_r <= {ChW{1'b0}};
        end else if (clr_i) begin
            prio_r    <= {ChW{1'b0}};
            lock_r    <= 1'b0;
            lock_ch_r <= {ChW{1'b0}};
        end else if (pop_s) begin
            prio_r <= next_ch(grant_s);
            lock_r <= 1'b0;
        end else if (rvalid_s) begin
            lock_r    <= 1'b1;
            lock_ch_r <= grant_s;
        end
    end

    // Storage array is intentionally not reset; reads of stale slots are masked by rvalid.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            storage_r[wch_i][wptr_r[wch_i][IdxW-1:0]] <= wdata_i;
        end
    end

    caliptra_prim_fifo_sync_mc_chk #(
        .Width        (Width),
        .Depth        (Depth),
        .NumCh        (NumCh),
        .AlmostFullTh (AlmostFullTh)
    ) u_chk (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .clr    (clr_i),
        .rvalid (rvalid_s),
        .rready (rready_i),
        .rdata  (rdata_o),
        .rch    (rch_o),
        .depth  (depth_o)
    );

endmodule

// Property checker for the multi-channel FIFO: parameter legality, read-port hold, occupancy bounds.
module caliptra_prim_fifo_sync_mc_chk #(
    parameter int unsigned Width        = 16,
    parameter int unsigned Depth        = 4,
    parameter int unsigned NumCh        = 2,
    parameter int unsigned AlmostFullTh = 3,
    localparam int unsigned DepthW      = $clog2(Depth + 1),
    localparam int unsigned ChW         = $clog2(NumCh)
) (
    input logic                    clk,
    input logic                    rst_n,
    input logic                    clr,
    input logic                    rvalid,
    input logic                    rready,
    input logic [Width-1:0]        rdata,
    input logic [ChW-1:0]          rch,
    input logic [NumCh*DepthW-1:0] depth
);

    params_legal_a: assert property (@(posedge clk)
        (Depth >= 2) && ((Depth & (Depth - 1)) == 0) && (NumCh >= 2) &&
        (AlmostFullTh >= 1) && (AlmostFullTh <= Depth));

    hold_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
        (rvalid && !rready && !clr) |=> (clr || ($stable(rdata) && $stable(rch))));

    for (genvar c = 0; c < NumCh; c++) begin : gen_depth_chk
        depth_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
            depth[c*DepthW +: DepthW] <= DepthW'(Depth));
    end

endmodule

// File: tb/tb_caliptra_prim_fifo_sync_mc.sv
// Randomized and directed bench for caliptra_prim_fifo_sync_mc, checked against a queue-based
// reference model of the per-channel FIFOs and the held round-robin read grant.

module tb_caliptra_prim_fifo_sync_mc;

    localparam int W   = 16;
    localparam int D   = 4;
    localparam int NCH = 2;
    localparam int AFT = 3;
    localparam int CHW = 1;
    localparam int DW  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              clr = 1'b0;
    logic              wvalid = 1'b0;
    logic [CHW-1:0]    wch = '0;
    logic [W-1:0]      wdata = '0;
    logic              wready;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [W-1:0]      rdata;
    logic [CHW-1:0]    rch;
    logic [NCH*DW-1:0] depth;
    logic [NCH-1:0]    afull;
    logic [NCH-1:0]    full;

    caliptra_prim_fifo_sync_mc dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clr_i    (clr),
        .wvalid_i (wvalid),
        .wch_i    (wch),
        .wdata_i  (wdata),
        .wready_o (wready),
        .rvalid_o (rvalid),
        .rready_i (rready),
        .rdata_o  (rdata),
        .rch_o    (rch),
        .depth_o  (depth),
        .afull_o  (afull),
        .full_o   (full)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: one queue per channel plus the rotating priority and the held grant.
    logic [W-1:0] mq [NCH][$];
    int prio    = 0;
    int held    = 0;
    int held_ch = 0;

    logic [CHW-1:0] obs_rch;
    logic [W-1:0]   obs_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_any();
        for (int c = 0; c < NCH; c++) if (mq[c].size() != 0) return 1;
        return 0;
    endfunction

    function automatic int m_grant();
        if (held != 0) return held_ch;
        for (int i = 0; i < NCH; i++) begin
            int c = (prio + i) % NCH;
            if (mq[c].size() != 0) return c;
        end
        return 0;
    endfunction

    task automatic m_clear();
        for (int c = 0; c < NCH; c++) mq[c].delete();
        prio = 0;
        held = 0;
        held_ch = 0;
    endtask

    task automatic chk_status(input string tag);
        for (int k = 0; k < NCH; k++) begin
            chk({tag, "_depth"}, depth[k*DW +: DW], mq[k].size());
            chk({tag, "_afull"}, afull[k], mq[k].size() >= AFT);
            chk({tag, "_full"},  full[k],  mq[k].size() == D);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare after settling, advance the model.
    task automatic step(input bit c, input bit wv, input int ch, input logic [W-1:0] d, input bit rr);
        int g;
        bit exp_rv;
        bit exp_wr;
        logic [W-1:0] exp_data;
        clr = c; wvalid = wv; wch = ch[CHW-1:0]; wdata = d; rready = rr;
        #1;
        g        = m_grant();
        exp_rv   = (m_any() != 0) && !c;
        exp_wr   = !c && (ch < NCH) && (mq[ch].size() < D);
        exp_data = '0;
        if (exp_rv) exp_data = mq[g][0];
        chk("wready", wready, exp_wr);
        chk("rvalid", rvalid, exp_rv);
        chk("rch",    rch,    exp_rv ? g : 0);
        chk("rdata",  rdata,  exp_data);
        chk_status("cyc");
        obs_rch   = rch;
        obs_rdata = rdata;
        @(posedge clk);
        if (c) begin
            m_clear();
        end else begin
            if (exp_rv && rr) begin
                void'(mq[g].pop_front());
                prio = (g + 1) % NCH;
                held = 0;
            end else if (exp_rv) begin
                held = 1;
                held_ch = g;
            end
            if (exp_wr && wv) mq[ch].push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clr = 1'b0; wvalid = 1'b0; wch = '0; wdata = '0; rready = 1'b0;
        m_clear();
        #1;
        chk("rst_wready", wready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata",  rdata,  0);
        chk("rst_rch",    rch,    0);
        chk("rst_depth",  depth,  0);
        chk("rst_afull",  afull,  0);
        chk("rst_full",   full,   0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();

        // Fill channel 0; almost-full appears with the third entry.
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 16'h1000 + 16'(i), 0);
            if (i == 1) chk("t2_afull_2", afull[0], 0);
            if (i == 2) chk("t2_afull_3", afull[0], 1);
        end
        wvalid = 1'b1; wch = '0; rready = 1'b0; clr = 1'b0;
        #1;
        chk("t2_full",   full[0], 1);
        chk("t2_depth",  depth[DW-1:0], 4);
        chk("t2_wready", wready, 0);

        // Full channel: write rejected while the same-cycle pop succeeds.
        step(0, 1, 0, 16'hBEEF, 1);
        chk("t5_popdata", obs_rdata, 16'h1000);
        #1;
        chk("t5_depth", depth[DW-1:0], 3);
        chk("t5_full",  full[0], 0);

        // Clear with rready high must not pop.
        step(1, 0, 0, 16'h0, 1);
        clr = 1'b0; wvalid = 1'b0; rready = 1'b0;
        #1;
        chk("t6_depth",  depth, 0);
        chk("t6_rvalid", rvalid, 0);
        chk("t6_wready", wready, 1);

        // Round-robin across two channels.
        step(0, 1, 0, 16'h3000, 0);
        step(0, 1, 1, 16'h3100, 0);
        step(0, 1, 0, 16'h3001, 0);
        step(0, 1, 1, 16'h3101, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 16'h0, 1);
            chk("t3_rch",   obs_rch, i % 2);
            chk("t3_rdata", obs_rdata, 16'h3000 + 16'((i % 2) * 256) + 16'(i / 2));
        end

        // Grant locked on channel 1 while channel 0 fills up.
        step(0, 1, 1, 16'h4100, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 16'h4000 + 16'(i), 0);
            chk("t4_hold_rch",   obs_rch, 1);
            chk("t4_hold_rdata", obs_rdata, 16'h4100);
        end
        step(0, 0, 0, 16'h0, 1);
        chk("t4_pop1", obs_rch, 1);
        step(0, 0, 0, 16'h0, 1);
        chk("t4_pop0_rch",  obs_rch, 0);
        chk("t4_pop0_data", obs_rdata, 16'h4000);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 1);

        // Random traffic with occasional clears and mid-transfer resets.
        for (int n = 0; n < 1500; n++) begin
            if (n % 500 == 250) do_reset();
            step($urandom_range(0, 31) == 0,
                 $urandom_range(0, 2) != 0,
                 int'($urandom_range(0, NCH - 1)),
                 W'($urandom_range(0, 65535)),
                 $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
